// File: rtl/overlay_pkg.sv
// ---------------------------------------------------------------------------
// overlay_pkg
//
// Shared definitions for the overlay compositor and the raster timing
// generator.
//   - mode_t           : compositing mode encodings
//   - RGB_W            : width of a packed 8:8:8 RGB pixel
//   - *_720P constants : default 1280x720 raster timing
//   - blend_rgb()      : per-channel 50 % mix of two RGB pixels
// ---------------------------------------------------------------------------
package overlay_pkg;

  localparam int RGB_W = 24;

  // Compositing modes. MODE_BG turns the window off even when ovl_on is set.
  typedef enum logic [1:0] {
    MODE_BG     = 2'd0,
    MODE_OPAQUE = 2'd1,
    MODE_KEY    = 2'd2,
    MODE_BLEND  = 2'd3
  } mode_t;

  // Default 720p60 raster (74.25 MHz pixel clock).
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int                CW_DEFAULT        = 12;
  localparam int                OVL_W_DEFAULT     = 256;
  localparam int                OVL_H_DEFAULT     = 256;
  localparam logic [RGB_W-1:0]  COLOR_KEY_DEFAULT = 24'hFF00FF;

  // Average of two pixels channel by channel. The 9-bit sum keeps the carry
  // and dropping bit 0 truncates, so 0x01 + 0xFF mixes to 0x80.
  function automatic logic [RGB_W-1:0] blend_rgb(input logic [RGB_W-1:0] a,
                                                 input logic [RGB_W-1:0] b);
    logic [8:0]       sum;
    logic [RGB_W-1:0] mix;
    mix = '0;
    for (int c = 0; c < 3; c++) begin
      sum            = {1'b0, a[c*8 +: 8]} + {1'b0, b[c*8 +: 8]};
      mix[c*8 +: 8]  = sum[8:1];
    end
    return mix;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// ---------------------------------------------------------------------------
// video_timing_counter
//
// Free-running raster position counters with the region decodes derived
// from them. Everything except hc/vc is a combinational decode of the
// registered counters, so consumers that need aligned sync must pipeline
// the decodes themselves.
//
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high; returns the raster to (0,0)
//   hc, vc       out  horizontal / vertical position
//   active       out  position lies inside the visible picture
//   hsync_on     out  position lies inside the horizontal sync pulse
//   vsync_on     out  line lies inside the vertical sync pulse
//   frame_start  out  position is (0,0)
//   frame_end    out  position is the last clock of the frame
// ---------------------------------------------------------------------------
module video_timing_counter
  import overlay_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          frame_start,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  assign h_wrap = (hc == H_LAST);

  // Pixel counter runs every clock; the line counter only steps when the
  // pixel counter wraps, and both return to zero together on the last
  // clock of the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      if (vc == V_LAST) begin
        vc <= '0;
      end else begin
        vc <= vc + CW'(1);
      end
    end else begin
      hc <= hc + CW'(1);
    end
  end

  assign active      = (hc < H_VIS) && (vc < V_VIS);
  assign hsync_on    = (hc >= HS_BEGIN) && (hc < HS_END);
  assign vsync_on    = (vc >= VS_BEGIN) && (vc < VS_END);
  assign frame_start = (hc == '0) && (vc == '0);
  assign frame_end   = h_wrap && (vc == V_LAST);

endmodule

// File: rtl/overlay_video_compositor.sv
// ---------------------------------------------------------------------------
// overlay_video_compositor
//
// Generates the HDMI raster and composites a streamed overlay window onto a
// flat background colour. Overlay pixels arrive in raster order over a
// valid/ready stream; one pixel is requested for every window position of
// every frame whether or not the reader keeps up.
//
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   ovl_on       in   overlay enable (taken at frame end)
//   mode         in   0 bg only, 1 opaque, 2 colour key, 3 50 % blend
//   ovl_x/ovl_y  in   window top-left (taken and clamped at frame end)
//   bg_rgb       in   background colour
//   pix_data     in   overlay pixel
//   pix_valid    in   overlay pixel available
//   pix_ready    out  pix_data is consumed on this edge
//   frame_start  out  raster is at (0,0)
//   underflow    out  sticky: a window slot found no pixel; cleared by reset
//   DE/HSYNC/VSYNC/data  out  transmitter signals, two clocks behind the
//                             raster counters and mutually aligned
// ---------------------------------------------------------------------------
module overlay_video_compositor
  import overlay_pkg::*;
#(
  parameter int               H_ACTIVE  = H_ACTIVE_720P,
  parameter int               H_FP      = H_FP_720P,
  parameter int               H_SYNC    = H_SYNC_720P,
  parameter int               H_BP      = H_BP_720P,
  parameter int               V_ACTIVE  = V_ACTIVE_720P,
  parameter int               V_FP      = V_FP_720P,
  parameter int               V_SYNC    = V_SYNC_720P,
  parameter int               V_BP      = V_BP_720P,
  parameter bit               HS_POL    = 1'b1,
  parameter bit               VS_POL    = 1'b1,
  parameter int               CW        = CW_DEFAULT,
  parameter int               OVL_W     = OVL_W_DEFAULT,
  parameter int               OVL_H     = OVL_H_DEFAULT,
  parameter logic [RGB_W-1:0] COLOR_KEY = COLOR_KEY_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ovl_on,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    ovl_x,
  input  logic [CW-1:0]    ovl_y,
  input  logic [RGB_W-1:0] bg_rgb,
  input  logic [RGB_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             frame_start,
  output logic             underflow,
  output logic             DE,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [RGB_W-1:0] data
);

  // Largest top-left position that still keeps the whole window visible.
  localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - OVL_W);
  localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - OVL_H);

  // Window compares are done one bit wider so x + OVL_W cannot wrap.
  localparam logic [CW:0] OVL_W_EXT = (CW+1)'(OVL_W);
  localparam logic [CW:0] OVL_H_EXT = (CW+1)'(OVL_H);

  // -------------------------------------------------------------------------
  // Stage 0: raster position
  // -------------------------------------------------------------------------
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          active;
  logic          hsync_on;
  logic          vsync_on;
  logic          frame_end;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CW       (CW)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .hc          (hc),
    .vc          (vc),
    .active      (active),
    .hsync_on    (hsync_on),
    .vsync_on    (vsync_on),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  // -------------------------------------------------------------------------
  // Frame latch: control inputs are taken only on the last clock of a frame
  // so a frame is always drawn with one consistent window and mode. The
  // position is clamped here, once, rather than in the per-pixel compare.
  // -------------------------------------------------------------------------
  logic          lat_on;
  mode_t         lat_mode;
  logic [CW-1:0] lat_x;
  logic [CW-1:0] lat_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_on   <= 1'b0;
      lat_mode <= MODE_BG;
      lat_x    <= '0;
      lat_y    <= '0;
    end else if (frame_end) begin
      lat_on   <= ovl_on;
      lat_mode <= mode_t'(mode);
      lat_x    <= (ovl_x > X_MAX) ? X_MAX : ovl_x;
      lat_y    <= (ovl_y > Y_MAX) ? Y_MAX : ovl_y;
    end
  end

  // -------------------------------------------------------------------------
  // Window compare and stream handshake. pix_ready depends only on
  // registered state so the reader sees a pure demand schedule; a missing
  // pixel costs its slot rather than stalling the raster.
  // -------------------------------------------------------------------------
  logic in_x;
  logic in_y;
  logic hit;
  logic take;

  assign in_x = ({1'b0, hc} >= {1'b0, lat_x}) &&
                ({1'b0, hc} <  ({1'b0, lat_x} + OVL_W_EXT));
  assign in_y = ({1'b0, vc} >= {1'b0, lat_y}) &&
                ({1'b0, vc} <  ({1'b0, lat_y} + OVL_H_EXT));

  assign hit       = active && lat_on && (lat_mode != MODE_BG) && in_x && in_y;
  assign take      = hit && pix_valid;
  assign pix_ready = hit;

  // Sticky starvation flag; the reader is expected to resynchronise on
  // frame_start, so only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (hit && !pix_valid) begin
      underflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: capture the position decodes together with the pixel and
  // background that belong to that position.
  // -------------------------------------------------------------------------
  logic             s1_active;
  logic             s1_hs;
  logic             s1_vs;
  logic             s1_take;
  mode_t            s1_mode;
  logic [RGB_W-1:0] s1_ovl;
  logic [RGB_W-1:0] s1_bg;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_take   <= 1'b0;
      s1_mode   <= MODE_BG;
      s1_ovl    <= '0;
      s1_bg     <= '0;
    end else begin
      s1_active <= active;
      s1_hs     <= hsync_on;
      s1_vs     <= vsync_on;
      s1_take   <= take;
      s1_mode   <= lat_mode;
      s1_ovl    <= pix_data;
      s1_bg     <= bg_rgb;
    end
  end

  // Colour selection. A lost slot (hit without a pixel) falls through to the
  // background, exactly like a position outside the window.
  logic [RGB_W-1:0] mixed;

  always_comb begin
    mixed = s1_bg;
    if (!s1_active) begin
      mixed = '0;
    end else if (s1_take) begin
      case (s1_mode)
        MODE_OPAQUE: mixed = s1_ovl;
        MODE_KEY:    mixed = (s1_ovl == COLOR_KEY) ? s1_bg : s1_ovl;
        MODE_BLEND:  mixed = blend_rgb(s1_ovl, s1_bg);
        default:     mixed = s1_bg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: output registers. Sync levels are applied here so every pin
  // leaves the block from a flop and stays aligned with DE and data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      DE    <= 1'b0;
      HSYNC <= ~HS_POL;
      VSYNC <= ~VS_POL;
      data  <= '0;
    end else begin
      DE    <= s1_active;
      HSYNC <= s1_hs ? HS_POL : ~HS_POL;
      VSYNC <= s1_vs ? VS_POL : ~VS_POL;
      data  <= mixed;
    end
  end

endmodule

// File: tb/tb_overlay_video_compositor.sv
// ---------------------------------------------------------------------------
// tb_overlay_video_compositor
//
// Small 8x4 raster (14x7 total) with a 2x2 overlay window. A behavioural
// model derives the raster position from the number of clocks since reset,
// keeps the per-frame latched controls, and queues the expected pin values
// two clocks ahead.
// ---------------------------------------------------------------------------
module tb_overlay_video_compositor;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int OW = 2, OH = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b1;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ovl_on = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] ovl_x = '0;
  logic [11:0] ovl_y = '0;
  logic [23:0] bg_rgb = '0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, frame_start, underflow, DE, HSYNC, VSYNC;
  logic [23:0] data;

  int n_cmp = 0;
  int n_bad = 0;

  overlay_video_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(12),
    .OVL_W(OW), .OVL_H(OH), .COLOR_KEY(KEY)
  ) dut (
    .clock(clock), .reset(reset), .ovl_on(ovl_on), .mode(mode),
    .ovl_x(ovl_x), .ovl_y(ovl_y), .bg_rgb(bg_rgb), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_start(frame_start),
    .underflow(underflow), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .data(data)
  );

  always #5 clock = ~clock;

  // Reference model state
  int          t;
  bit          l_on;
  int          l_mode, l_x, l_y;
  bit          m_uf;
  logic [26:0] exp_q[$];

  function automatic bit m_hit_at(int tt);
    int h, v;
    h = tt % HT;
    v = (tt / HT) % VT;
    return (h < HA) && (v < VA) && l_on && (l_mode != 0) &&
           (h >= l_x) && (h < l_x + OW) && (v >= l_y) && (v < l_y + OH);
  endfunction

  function automatic logic [23:0] composite(int md, logic [23:0] o, logic [23:0] b);
    logic [23:0] r;
    r = b;
    if (md == 1) r = o;
    else if (md == 2) r = (o == KEY) ? b : o;
    else if (md == 3)
      for (int c = 0; c < 3; c++)
        r[c*8 +: 8] = 8'((int'(o[c*8 +: 8]) + int'(b[c*8 +: 8])) / 2);
    return r;
  endfunction

  task automatic model_reset();
    logic [26:0] rst_val;
    rst_val = {1'b0, !HS_POL, !VS_POL, 24'h0};
    t = 0; l_on = 0; l_mode = 0; l_x = 0; l_y = 0; m_uf = 0;
    exp_q.delete();
    exp_q.push_back(rst_val);
    exp_q.push_back(rst_val);
  endtask

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_step();
    int h, v;
    bit act, hit, hs, vs;
    logic [23:0] d;
    h = t % HT;
    v = (t / HT) % VT;
    act = (h < HA) && (v < VA);
    hit = m_hit_at(t);
    hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
    if (!act) d = 24'h0;
    else if (hit && pix_valid) d = composite(l_mode, pix_data, bg_rgb);
    else d = bg_rgb;
    if (hit && !pix_valid) m_uf = 1;
    void'(exp_q.pop_front());
    exp_q.push_back({act, hs ? HS_POL : !HS_POL, vs ? VS_POL : !VS_POL, d});
    if (h == HT - 1 && v == VT - 1) begin
      l_on = ovl_on;
      l_mode = int'(mode);
      l_x = (int'(ovl_x) > HA - OW) ? HA - OW : int'(ovl_x);
      l_y = (int'(ovl_y) > VA - OH) ? VA - OH : int'(ovl_y);
    end
    t++;
  endtask

  function automatic int to_boundary();
    return (FRAME - (t % FRAME)) % FRAME;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (DE !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_de got %b want 0", DE); end
    n_cmp++; if (HSYNC !== !HS_POL) begin n_bad++; $display("[TB] FAIL reset_hsync got %b want %b", HSYNC, !HS_POL); end
    n_cmp++; if (VSYNC !== !VS_POL) begin n_bad++; $display("[TB] FAIL reset_vsync got %b want %b", VSYNC, !VS_POL); end
    n_cmp++; if (data !== 24'h0) begin n_bad++; $display("[TB] FAIL reset_data got %h want 000000", data); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready got %b want 0", pix_ready); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_underflow got %b want 0", underflow); end
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_frame_start got %b want 1", frame_start); end
  endtask

  task automatic test_timing();
    int de_n = 0, hs_n = 0, vs_n = 0, fs_n = 0;
    ovl_on = 1'b0; mode = 2'd0; bg_rgb = $urandom; pix_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix_data = $urandom;
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL timing t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      de_n += int'(DE); hs_n += int'(HSYNC == HS_POL); vs_n += int'(VSYNC == VS_POL);
      fs_n += int'(frame_start);
      model_step();
      @(posedge clock); #1;
    end
    n_cmp++; if (de_n != 64) begin n_bad++; $display("[TB] FAIL timing_de_count got %0d want 64", de_n); end
    n_cmp++; if (hs_n != 28) begin n_bad++; $display("[TB] FAIL timing_hsync_count got %0d want 28", hs_n); end
    n_cmp++; if (vs_n != 28) begin n_bad++; $display("[TB] FAIL timing_vsync_count got %0d want 28", vs_n); end
    n_cmp++; if (fs_n != 2) begin n_bad++; $display("[TB] FAIL timing_frame_start_count got %0d want 2", fs_n); end
  endtask

  task automatic test_opaque();
    int cycles, rdy_n = 0;
    ovl_on = 1'b1; mode = 2'd1; ovl_x = 12'd3; ovl_y = 12'd1; pix_valid = 1'b1;
    bg_rgb = $urandom;
    cycles = to_boundary() + 2 * FRAME;
    for (int i = 0; i < cycles; i++) begin
      pix_data = $urandom;
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL opaque t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      if (i >= cycles - FRAME) rdy_n += int'(pix_ready);
      model_step();
      @(posedge clock); #1;
    end
    n_cmp++; if (rdy_n != OW * OH) begin n_bad++; $display("[TB] FAIL opaque_ready_count got %0d want %0d", rdy_n, OW * OH); end
  endtask

  task automatic test_color_key();
    int cycles, plain_n = 0, key_n = 0;
    bit alt = 0;
    mode = 2'd2; bg_rgb = 24'h0A0B0C; pix_valid = 1'b1;
    cycles = to_boundary() + 2 * FRAME;
    for (int i = 0; i < cycles; i++) begin
      pix_data = alt ? 24'h123456 : KEY;
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL color_key t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      plain_n += int'(DE && data == 24'h123456);
      key_n   += int'(DE && data == KEY);
      if (pix_ready) alt = !alt;
      model_step();
      @(posedge clock); #1;
    end
    // First frame is still opaque (key colour shown), second is keyed.
    n_cmp++; if (plain_n != 4) begin n_bad++; $display("[TB] FAIL key_plain_count got %0d want 4", plain_n); end
    n_cmp++; if (key_n != 2) begin n_bad++; $display("[TB] FAIL key_keyed_count got %0d want 2", key_n); end
  endtask

  task automatic test_blend();
    int cycles, mix_n = 0;
    mode = 2'd3; bg_rgb = 24'h00FF10; pix_valid = 1'b1;
    cycles = to_boundary() + 3 * FRAME;
    for (int i = 0; i < cycles; i++) begin
      if (i < cycles - FRAME) pix_data = 24'hFF0111;
      else begin pix_data = $urandom; bg_rgb = $urandom; end
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL blend t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      if (i < cycles - FRAME) mix_n += int'(DE && data == 24'h7F8010);
      model_step();
      @(posedge clock); #1;
    end
    n_cmp++; if (mix_n != 4) begin n_bad++; $display("[TB] FAIL blend_mix_count got %0d want 4", mix_n); end
  endtask

  task automatic test_move();
    int cycles, base, cnt_a = 0, cnt_b = 0;
    mode = 2'd1; ovl_x = 12'd3; pix_valid = 1'b1; bg_rgb = $urandom;
    base = to_boundary();
    cycles = base + 2 * FRAME;
    for (int i = 0; i < cycles; i++) begin
      pix_data = $urandom;
      if (i == base + 20) ovl_x = 12'd7;
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL move t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      if (i >= base + 20 && i < base + FRAME && (t % HT == 3 || t % HT == 4)) cnt_a += int'(pix_ready);
      if (i >= base + FRAME && (t % HT == 6 || t % HT == 7)) cnt_b += int'(pix_ready);
      model_step();
      @(posedge clock); #1;
    end
    n_cmp++; if (cnt_a != 2) begin n_bad++; $display("[TB] FAIL move_same_frame got %0d want 2", cnt_a); end
    n_cmp++; if (cnt_b != 4) begin n_bad++; $display("[TB] FAIL move_clamped_frame got %0d want 4", cnt_b); end
  endtask

  task automatic test_underflow();
    int cycles;
    bit dropped = 0;
    ovl_y = 12'd5; bg_rgb = $urandom;
    cycles = to_boundary() + 2 * FRAME + 35;
    for (int i = 0; i < cycles; i++) begin
      pix_data = $urandom;
      pix_valid = 1'b1;
      if (i >= cycles - FRAME - 35 && !dropped && m_hit_at(t)) begin
        pix_valid = 1'b0;
        dropped = 1;
      end
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL underflow t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      model_step();
      @(posedge clock); #1;
    end
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("[TB] FAIL underflow_sticky got %b want 1", underflow); end
    n_cmp++; if (DE !== 1'b1) begin n_bad++; $display("[TB] FAIL underflow_pre_reset_de got %b want 1", DE); end
    // Reset in the middle of an active line.
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (DE !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_de got %b want 0", DE); end
    n_cmp++; if (HSYNC !== !HS_POL || VSYNC !== !VS_POL) begin n_bad++; $display("[TB] FAIL midreset_sync got %b%b want %b%b", HSYNC, VSYNC, !HS_POL, !VS_POL); end
    n_cmp++; if (data !== 24'h0) begin n_bad++; $display("[TB] FAIL midreset_data got %h want 000000", data); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_ready got %b want 0", pix_ready); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_underflow got %b want 0", underflow); end
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset_frame_start got %b want 1", frame_start); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      ovl_on = ($urandom % 4) != 0;
      mode = 2'($urandom);
      ovl_x = 12'($urandom_range(0, 10));
      ovl_y = 12'($urandom_range(0, 5));
      bg_rgb = ($urandom % 8 == 0) ? KEY : 24'($urandom);
      pix_data = ($urandom % 4 == 0) ? KEY : 24'($urandom);
      pix_valid = ($urandom % 8) != 0;
      @(negedge clock);
      n_cmp++;
      if ({DE, HSYNC, VSYNC, data} !== exp_q[0] || pix_ready !== m_hit_at(t) ||
          frame_start !== bit'(t % FRAME == 0) || underflow !== m_uf) begin
        n_bad++;
        $display("[TB] FAIL random t=%0d got %h rdy=%b fs=%b uf=%b want %h rdy=%b fs=%b uf=%b",
                 t, {DE, HSYNC, VSYNC, data}, pix_ready, frame_start, underflow,
                 exp_q[0], m_hit_at(t), t % FRAME == 0, m_uf);
      end
      model_step();
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_opaque();
    test_color_key();
    test_blend();
    test_move();
    test_underflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
